// File: rtl/reorder_buffer_if.sv
// Reorder buffer bundle: dual dispatch, three completion ports, dual retire and status.
interface reorder_buffer_if;
  logic        disp_valid_1, disp_valid_2;
  logic [5:0]  disp_rd_1, disp_rd_2;
  logic [6:0]  disp_opcode_1, disp_opcode_2;
  logic        cmp_valid_1, cmp_valid_2, cmp_valid_3;
  logic [4:0]  cmp_idx_1, cmp_idx_2, cmp_idx_3;
  logic [31:0] cmp_val_1, cmp_val_2, cmp_val_3;
  logic        full_o;
  logic [4:0]  rob_tail_o;
  logic        wr_en_1, wr_en_2;
  logic [5:0]  wr_addr_1, wr_addr_2;
  logic [31:0] wr_data_1, wr_data_2;
  logic [1:0]  num_retired_o;
  logic [31:0] ready_reg_1, ready_reg_2;
  logic [63:0] reg_ready_o;

  modport master (
    output disp_valid_1, disp_valid_2, disp_rd_1, disp_rd_2, disp_opcode_1, disp_opcode_2,
    output cmp_valid_1, cmp_valid_2, cmp_valid_3, cmp_idx_1, cmp_idx_2, cmp_idx_3,
    output cmp_val_1, cmp_val_2, cmp_val_3,
    input  full_o, rob_tail_o, wr_en_1, wr_en_2, wr_addr_1, wr_addr_2, wr_data_1, wr_data_2,
    input  num_retired_o, ready_reg_1, ready_reg_2, reg_ready_o
  );

  modport slave (
    input  disp_valid_1, disp_valid_2, disp_rd_1, disp_rd_2, disp_opcode_1, disp_opcode_2,
    input  cmp_valid_1, cmp_valid_2, cmp_valid_3, cmp_idx_1, cmp_idx_2, cmp_idx_3,
    input  cmp_val_1, cmp_val_2, cmp_val_3,
    output full_o, rob_tail_o, wr_en_1, wr_en_2, wr_addr_1, wr_addr_2, wr_data_1, wr_data_2,
    output num_retired_o, ready_reg_1, ready_reg_2, reg_ready_o
  );
endinterface

// File: rtl/reorder_buffer.sv
// 32-entry circular reorder buffer: two-wide in-order dispatch and retire, three completion ports.
module reorder_buffer #(
  parameter int unsigned DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  reorder_buffer_if.slave rob
);
  localparam logic [6:0] OP_SW = 7'b0100011;

  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
  logic [5:0]       rd_q  [DEPTH];
  logic [5:0]       rd_d  [DEPTH];
  logic [6:0]       op_q  [DEPTH];
  logic [6:0]       op_d  [DEPTH];
  logic [31:0]      val_q [DEPTH];
  logic [31:0]      val_d [DEPTH];

  logic [4:0] head_q, head_d, tail_q, tail_d;
  logic [5:0] count_q, count_d;
  logic       full_q, full_d;

  logic        wr_en_1_q, wr_en_1_d, wr_en_2_q, wr_en_2_d;
  logic [5:0]  wr_addr_1_q, wr_addr_1_d, wr_addr_2_q, wr_addr_2_d;
  logic [31:0] wr_data_1_q, wr_data_1_d, wr_data_2_q, wr_data_2_d;
  logic [1:0]  num_ret_q, num_ret_d;
  logic [63:0] mask_q, mask_d;

  logic [4:0] head_nx, slot2;
  logic       ret_0, ret_1, wr_0, wr_1, disp_1, disp_2;
  logic [1:0] n_ret, n_disp;

  // Retirement sees only done bits registered before this edge.
  assign head_nx = head_q + 5'd1;
  assign ret_0   = valid_q[head_q] & done_q[head_q];
  assign ret_1   = ret_0 & valid_q[head_nx] & done_q[head_nx];
  assign wr_0    = ret_0 & (op_q[head_q]  != OP_SW) & (rd_q[head_q]  != 6'd0);
  assign wr_1    = ret_1 & (op_q[head_nx] != OP_SW) & (rd_q[head_nx] != 6'd0);
  assign n_ret   = {1'b0, ret_0} + {1'b0, ret_1};

  assign disp_1  = ~full_q & rob.disp_valid_1;
  assign disp_2  = ~full_q & rob.disp_valid_2;
  assign slot2   = disp_1 ? tail_q + 5'd1 : tail_q;
  assign n_disp  = {1'b0, disp_1} + {1'b0, disp_2};

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    rd_d    = rd_q;
    op_d    = op_q;
    val_d   = val_q;

    // Later ports overwrite earlier ones, so the highest k wins on a shared index.
    if (rob.cmp_valid_1 && valid_q[rob.cmp_idx_1]) begin
      done_d[rob.cmp_idx_1] = 1'b1;
      val_d[rob.cmp_idx_1]  = rob.cmp_val_1;
    end
    if (rob.cmp_valid_2 && valid_q[rob.cmp_idx_2]) begin
      done_d[rob.cmp_idx_2] = 1'b1;
      val_d[rob.cmp_idx_2]  = rob.cmp_val_2;
    end
    if (rob.cmp_valid_3 && valid_q[rob.cmp_idx_3]) begin
      done_d[rob.cmp_idx_3] = 1'b1;
      val_d[rob.cmp_idx_3]  = rob.cmp_val_3;
    end

    if (ret_0) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    if (ret_1) begin
      valid_d[head_nx] = 1'b0;
      done_d[head_nx]  = 1'b0;
    end

    if (disp_1) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      rd_d[tail_q]    = rob.disp_rd_1;
      op_d[tail_q]    = rob.disp_opcode_1;
      val_d[tail_q]   = '0;
    end
    if (disp_2) begin
      valid_d[slot2] = 1'b1;
      done_d[slot2]  = 1'b0;
      rd_d[slot2]    = rob.disp_rd_2;
      op_d[slot2]    = rob.disp_opcode_2;
      val_d[slot2]   = '0;
    end

    head_d  = head_q + {3'b000, n_ret};
    tail_d  = tail_q + {3'b000, n_disp};
    count_d = count_q + {4'b0000, n_disp} - {4'b0000, n_ret};
    full_d  = (count_d >= 6'd31);
  end

  // Writing retirements are packed into port 1 first, then port 2.
  always_comb begin
    wr_en_1_d   = 1'b0;
    wr_en_2_d   = 1'b0;
    wr_addr_1_d = '0;
    wr_addr_2_d = '0;
    wr_data_1_d = '0;
    wr_data_2_d = '0;
    mask_d      = '0;
    num_ret_d   = {1'b0, wr_0} + {1'b0, wr_1};
    if (wr_0) begin
      wr_en_1_d   = 1'b1;
      wr_addr_1_d = rd_q[head_q];
      wr_data_1_d = val_q[head_q];
      mask_d[rd_q[head_q]] = 1'b1;
      if (wr_1) begin
        wr_en_2_d   = 1'b1;
        wr_addr_2_d = rd_q[head_nx];
        wr_data_2_d = val_q[head_nx];
      end
    end else if (wr_1) begin
      wr_en_1_d   = 1'b1;
      wr_addr_1_d = rd_q[head_nx];
      wr_data_1_d = val_q[head_nx];
    end
    if (wr_1) mask_d[rd_q[head_nx]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        op_q[i]  <= '0;
        val_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      wr_en_1_q   <= 1'b0;
      wr_en_2_q   <= 1'b0;
      wr_addr_1_q <= '0;
      wr_addr_2_q <= '0;
      wr_data_1_q <= '0;
      wr_data_2_q <= '0;
      num_ret_q   <= '0;
      mask_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      done_q      <= done_d;
      rd_q        <= rd_d;
      op_q        <= op_d;
      val_q       <= val_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      full_q      <= full_d;
      wr_en_1_q   <= wr_en_1_d;
      wr_en_2_q   <= wr_en_2_d;
      wr_addr_1_q <= wr_addr_1_d;
      wr_addr_2_q <= wr_addr_2_d;
      wr_data_1_q <= wr_data_1_d;
      wr_data_2_q <= wr_data_2_d;
      num_ret_q   <= num_ret_d;
      mask_q      <= mask_d;
    end
  end

  assign rob.full_o        = full_q;
  assign rob.rob_tail_o    = tail_q;
  assign rob.wr_en_1       = wr_en_1_q;
  assign rob.wr_en_2       = wr_en_2_q;
  assign rob.wr_addr_1     = wr_addr_1_q;
  assign rob.wr_addr_2     = wr_addr_2_q;
  assign rob.wr_data_1     = wr_data_1_q;
  assign rob.wr_data_2     = wr_data_2_q;
  assign rob.num_retired_o = num_ret_q;
  assign rob.ready_reg_1   = {26'd0, wr_addr_1_q};
  assign rob.ready_reg_2   = {26'd0, wr_addr_2_q};
  assign rob.reg_ready_o   = mask_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with an in-order queue model checked every cycle.
module tb_reorder_buffer;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  reorder_buffer_if bus();
  reorder_buffer #(.DEPTH(32)) dut (.clk(clk), .rst_n(rst_n), .rob(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  idx;
    logic [5:0]  rd;
    logic [6:0]  op;
    bit          done;
    logic [31:0] val;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_tail;
  bit          m_full;
  logic        e_en1, e_en2;
  logic [5:0]  e_addr1, e_addr2;
  logic [31:0] e_data1, e_data2;
  logic [1:0]  e_num;
  logic [63:0] e_mask;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_clear();
    mq.delete();
    m_tail = 0; m_full = 0;
    e_en1 = 0; e_en2 = 0; e_addr1 = '0; e_addr2 = '0;
    e_data1 = '0; e_data2 = '0; e_num = '0; e_mask = '0;
  endtask

  task automatic model_complete(logic v, logic [4:0] idx, logic [31:0] val);
    if (v) foreach (mq[j]) if (mq[j].idx == idx) begin mq[j].done = 1; mq[j].val = val; end
  endtask

  task automatic model_step();
    ent_t ret[$];
    ent_t wr[$];
    ent_t e;
    if (mq.size() > 0 && mq[0].done) begin
      ret.push_back(mq[0]);
      if (mq.size() > 1 && mq[1].done) ret.push_back(mq[1]);
    end
    model_complete(bus.cmp_valid_1, bus.cmp_idx_1, bus.cmp_val_1);
    model_complete(bus.cmp_valid_2, bus.cmp_idx_2, bus.cmp_val_2);
    model_complete(bus.cmp_valid_3, bus.cmp_idx_3, bus.cmp_val_3);
    foreach (ret[j]) void'(mq.pop_front());
    if (!m_full) begin
      if (bus.disp_valid_1) begin
        e.idx = 5'(m_tail); e.rd = bus.disp_rd_1; e.op = bus.disp_opcode_1; e.done = 0; e.val = '0;
        mq.push_back(e); m_tail = (m_tail + 1) % 32;
      end
      if (bus.disp_valid_2) begin
        e.idx = 5'(m_tail); e.rd = bus.disp_rd_2; e.op = bus.disp_opcode_2; e.done = 0; e.val = '0;
        mq.push_back(e); m_tail = (m_tail + 1) % 32;
      end
    end
    m_full = (mq.size() >= 31);
    foreach (ret[j]) if (ret[j].op != OP_SW && ret[j].rd != 0) wr.push_back(ret[j]);
    e_num = 2'(wr.size());
    e_en1 = 0; e_en2 = 0; e_addr1 = '0; e_addr2 = '0; e_data1 = '0; e_data2 = '0; e_mask = '0;
    if (wr.size() > 0) begin
      e_en1 = 1; e_addr1 = wr[0].rd; e_data1 = wr[0].val; e_mask[wr[0].rd] = 1'b1;
    end
    if (wr.size() > 1) begin
      e_en2 = 1; e_addr2 = wr[1].rd; e_data2 = wr[1].val; e_mask[wr[1].rd] = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_clear();
    else model_step();
  end

  always @(negedge clk) begin
    chk("full_o",        64'(bus.full_o),        64'(m_full));
    chk("rob_tail_o",    64'(bus.rob_tail_o),    64'(m_tail));
    chk("wr_en_1",       64'(bus.wr_en_1),       64'(e_en1));
    chk("wr_en_2",       64'(bus.wr_en_2),       64'(e_en2));
    chk("wr_addr_1",     64'(bus.wr_addr_1),     64'(e_addr1));
    chk("wr_addr_2",     64'(bus.wr_addr_2),     64'(e_addr2));
    chk("wr_data_1",     64'(bus.wr_data_1),     64'(e_data1));
    chk("wr_data_2",     64'(bus.wr_data_2),     64'(e_data2));
    chk("num_retired_o", 64'(bus.num_retired_o), 64'(e_num));
    chk("ready_reg_1",   64'(bus.ready_reg_1),   64'(e_addr1));
    chk("ready_reg_2",   64'(bus.ready_reg_2),   64'(e_addr2));
    chk("reg_ready_o",   bus.reg_ready_o,        e_mask);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input bit v1, input logic [5:0] r1, input logic [6:0] o1,
                          input bit v2, input logic [5:0] r2, input logic [6:0] o2);
    bus.disp_valid_1 = v1; bus.disp_rd_1 = r1; bus.disp_opcode_1 = o1;
    bus.disp_valid_2 = v2; bus.disp_rd_2 = r2; bus.disp_opcode_2 = o2;
  endtask

  task automatic set_cmp(input int k, input bit v, input logic [4:0] idx, input logic [31:0] val);
    case (k)
      1: begin bus.cmp_valid_1 = v; bus.cmp_idx_1 = idx; bus.cmp_val_1 = val; end
      2: begin bus.cmp_valid_2 = v; bus.cmp_idx_2 = idx; bus.cmp_val_2 = val; end
      default: begin bus.cmp_valid_3 = v; bus.cmp_idx_3 = idx; bus.cmp_val_3 = val; end
    endcase
  endtask

  task automatic clr_in();
    set_disp(0, '0, '0, 0, '0, '0);
    set_cmp(1, 0, '0, '0);
    set_cmp(2, 0, '0, '0);
    set_cmp(3, 0, '0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_in();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    cyc();
    chk("reset full_o", 64'(bus.full_o), 64'd0);
    chk("reset rob_tail_o", 64'(bus.rob_tail_o), 64'd0);
    chk("reset reg_ready_o", bus.reg_ready_o, 64'd0);
    do_reset();

    // ADD rd5 / ADDI rd6, completed out of order
    set_disp(1, 6'd5, OP_ADD, 1, 6'd6, OP_ADDI);
    cyc();
    clr_in(); set_cmp(1, 1, 5'd1, 32'd7);
    cyc();
    clr_in(); set_cmp(1, 1, 5'd0, 32'd9);
    cyc();
    chk("ooo no early retire", 64'(bus.num_retired_o), 64'd0);
    clr_in();
    cyc();
    chk("ooo num_retired", 64'(bus.num_retired_o), 64'd2);
    chk("ooo ready_reg_1", 64'(bus.ready_reg_1), 64'd5);
    chk("ooo ready_reg_2", 64'(bus.ready_reg_2), 64'd6);
    chk("ooo wr_data_1", 64'(bus.wr_data_1), 64'd9);
    chk("ooo wr_data_2", 64'(bus.wr_data_2), 64'd7);
    chk("ooo reg_ready", bus.reg_ready_o, 64'h60);
    cyc();
    chk("ooo one-cycle pulse", 64'(bus.wr_en_1), 64'd0);

    // SW then LW rd3
    do_reset();
    set_disp(1, 6'd2, OP_SW, 1, 6'd3, OP_LW);
    cyc();
    clr_in(); set_cmp(1, 1, 5'd0, 32'd11); set_cmp(2, 1, 5'd1, 32'd33);
    cyc();
    clr_in();
    cyc();
    chk("sw num_retired", 64'(bus.num_retired_o), 64'd1);
    chk("sw ready_reg_1", 64'(bus.ready_reg_1), 64'd3);
    chk("sw wr_en_1", 64'(bus.wr_en_1), 64'd1);
    chk("sw wr_en_2", 64'(bus.wr_en_2), 64'd0);
    chk("sw wr_data_1", 64'(bus.wr_data_1), 64'd33);
    chk("sw reg_ready", bus.reg_ready_o, 64'h8);

    // Same rd twice, with same-index completion conflicts; then rd0 and rd63
    do_reset();
    set_disp(1, 6'd4, OP_ADD, 1, 6'd4, OP_ADD);
    cyc();
    clr_in();
    set_cmp(1, 1, 5'd1, 32'hdead); set_cmp(2, 1, 5'd1, 32'd2); set_cmp(3, 1, 5'd0, 32'd1);
    cyc();
    clr_in();
    cyc();
    chk("dup wr_en_1", 64'(bus.wr_en_1), 64'd1);
    chk("dup wr_en_2", 64'(bus.wr_en_2), 64'd1);
    chk("dup wr_addr_2", 64'(bus.wr_addr_2), 64'd4);
    chk("dup wr_data_1", 64'(bus.wr_data_1), 64'd1);
    chk("dup wr_data_2 final", 64'(bus.wr_data_2), 64'd2);
    chk("dup reg_ready", bus.reg_ready_o, 64'h10);
    set_disp(1, 6'd0, OP_ADD, 1, 6'd63, OP_ADD);
    cyc();
    clr_in(); set_cmp(1, 1, 5'd2, 32'd5); set_cmp(2, 1, 5'd3, 32'd6);
    cyc();
    clr_in();
    cyc();
    chk("rd0 num_retired", 64'(bus.num_retired_o), 64'd1);
    chk("rd0 ready_reg_1", 64'(bus.ready_reg_1), 64'd63);
    chk("rd0 wr_data_1", 64'(bus.wr_data_1), 64'd6);
    chk("rd0 reg_ready", bus.reg_ready_o, 64'h8000_0000_0000_0000);

    // Fill to 31 entries, then drain
    do_reset();
    for (int i = 0; i < 15; i++) begin
      set_disp(1, 6'((i % 8) + 1), OP_ADD, 1, 6'((i % 8) + 1), OP_ADD);
      cyc();
    end
    chk("fill30 full_o", 64'(bus.full_o), 64'd0);
    chk("fill30 tail", 64'(bus.rob_tail_o), 64'd30);
    set_disp(1, 6'd9, OP_ADD, 0, '0, '0);
    cyc();
    chk("fill31 full_o", 64'(bus.full_o), 64'd1);
    chk("fill31 tail", 64'(bus.rob_tail_o), 64'd31);
    set_disp(1, 6'd10, OP_ADD, 1, 6'd11, OP_ADD);
    cyc();
    chk("full ignore tail", 64'(bus.rob_tail_o), 64'd31);
    chk("full ignore full_o", 64'(bus.full_o), 64'd1);
    clr_in();
    for (int j = 0; j < 31; j += 3) begin
      clr_in();
      set_cmp(1, 1, 5'(j), 32'(j + 100));
      if (j + 1 < 31) set_cmp(2, 1, 5'(j + 1), 32'(j + 101));
      if (j + 2 < 31) set_cmp(3, 1, 5'(j + 2), 32'(j + 102));
      cyc();
    end
    clr_in();
    repeat (20) cyc();
    chk("drained full_o", 64'(bus.full_o), 64'd0);

    // Wrap: 40 single dispatches, each completed one cycle later
    do_reset();
    for (int i = 0; i < 40; i++) begin
      clr_in();
      set_disp(1, 6'((i % 63) + 1), OP_ADD, 0, '0, '0);
      if (i > 0) set_cmp(1, 1, 5'((i - 1) % 32), 32'((i - 1) * 7 + 3));
      cyc();
    end
    clr_in(); set_cmp(1, 1, 5'd7, 32'd276);
    cyc();
    clr_in();
    cyc();
    chk("wrap last data", 64'(bus.wr_data_1), 64'd276);
    chk("wrap last addr", 64'(bus.wr_addr_1), 64'd40);
    chk("wrap tail", 64'(bus.rob_tail_o), 64'd8);
    cyc();

    // Asynchronous reset with entries in flight
    do_reset();
    set_disp(1, 6'd1, OP_ADD, 1, 6'd2, OP_ADD);
    cyc();
    set_disp(1, 6'd3, OP_ADD, 1, 6'd4, OP_ADD);
    set_cmp(1, 1, 5'd0, 32'd10); set_cmp(2, 1, 5'd1, 32'd20);
    cyc();
    clr_in(); set_disp(1, 6'd5, OP_ADD, 0, '0, '0);
    cyc();
    clr_in();
    chk("pre-reset wr_en_1", 64'(bus.wr_en_1), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async wr_en_1", 64'(bus.wr_en_1), 64'd0);
    chk("async num_retired", 64'(bus.num_retired_o), 64'd0);
    chk("async reg_ready", bus.reg_ready_o, 64'd0);
    chk("async tail", 64'(bus.rob_tail_o), 64'd0);
    cyc();
    rst_n = 1'b1;
    set_disp(1, 6'd9, OP_ADD, 0, '0, '0);
    cyc();
    chk("post-reset tail", 64'(bus.rob_tail_o), 64'd1);
    clr_in(); set_cmp(1, 1, 5'd0, 32'h1234);
    cyc();
    clr_in();
    cyc();
    chk("post-reset idx0 data", 64'(bus.wr_data_1), 64'h1234);
    chk("post-reset idx0 addr", 64'(bus.wr_addr_1), 64'd9);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
